// File: rtl/inference_sequencer.sv
// rtl/inference_sequencer.sv - layer/neuron scheduler driving instr RAM, weight ROM, ping-pong neuron RAM and MAC strobes
// Optional feature macro: SEQ_HOLD_EN (adds a 'hold' input that freezes MAC/DRAIN/WRITE progress)
module inference_sequencer #(
  parameter int                ADDR_W         = 8,
  parameter logic [ADDR_W-1:0] BASE_LOW       = ADDR_W'(0),
  parameter logic [ADDR_W-1:0] BASE_HIGH      = ADDR_W'(20),
  parameter int                MAC_LATENCY    = 2,
  parameter logic [ADDR_W-1:0] END_OF_PROGRAM = ADDR_W'(8'hFF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
`ifdef SEQ_HOLD_EN
  input  logic              hold,
`endif
  output logic [ADDR_W-1:0] instr_addr,
  input  logic [ADDR_W-1:0] instr_data,
  output logic [ADDR_W-1:0] weight_addr,
  output logic [ADDR_W-1:0] neuro_read_addr,
  output logic [ADDR_W-1:0] neuro_write_addr,
  output logic              neuro_wr_en,
  output logic              mac_rst,
  output logic              mac_forget,
  output logic              mac_acc_en,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] result_base_address,
  output logic [ADDR_W-1:0] result_word_count
);

  localparam int CNT_W = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(MAC_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH0,
    S_FETCH,
    S_MAC,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ip_q, ip_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rd_base_q, rd_base_d;
  logic [ADDR_W-1:0] wr_base_q, wr_base_d;
  logic [ADDR_W-1:0] nprev_q, nprev_d;
  logic [ADDR_W-1:0] ncur_q, ncur_d;
  logic [ADDR_W-1:0] i_q, i_d;
  logic [ADDR_W-1:0] j_q, j_d;
  logic [CNT_W-1:0]  drain_q, drain_d;
  logic [ADDR_W-1:0] res_base_q, res_base_d;
  logic [ADDR_W-1:0] res_count_q, res_count_d;
  logic              acc_en_q, acc_en_d;
  logic              wr_en_q, wr_en_d;
  logic              forget_q, forget_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              mac_rst_q, mac_rst_d;

  logic              is_term;
  logic              hold_active;

  assign is_term = (instr_data == END_OF_PROGRAM) || (instr_data == '0);

`ifdef SEQ_HOLD_EN
  // Hold only stalls the datapath states; fetch and idle/done states ignore it.
  assign hold_active = hold && ((state_q == S_MAC) || (state_q == S_DRAIN) || (state_q == S_WRITE));
`else
  assign hold_active = 1'b0;
`endif

  // Next-state and counter computation for the layer/neuron walk.
  always_comb begin
    state_d     = state_q;
    ip_d        = ip_q;
    wptr_d      = wptr_q;
    rd_base_d   = rd_base_q;
    wr_base_d   = wr_base_q;
    nprev_d     = nprev_q;
    ncur_d      = ncur_q;
    i_d         = i_q;
    j_d         = j_q;
    drain_d     = drain_q;
    res_base_d  = res_base_q;
    res_count_d = res_count_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          ip_d      = '0;
          wptr_d    = '0;
          rd_base_d = BASE_LOW;
          wr_base_d = BASE_HIGH;
          state_d   = S_FETCH0;
        end
      end
      S_FETCH0: begin
        if (is_term) begin
          res_base_d  = BASE_LOW;
          res_count_d = '0;
          state_d     = S_DONE;
        end else begin
          nprev_d = instr_data;
          ip_d    = ADDR_W'(1);
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (is_term) begin
          res_base_d  = rd_base_q;
          res_count_d = nprev_q;
          state_d     = S_DONE;
        end else begin
          ncur_d  = instr_data;
          i_d     = '0;
          j_d     = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        if (!hold_active) begin
          wptr_d = wptr_q + 1'b1;
          i_d    = i_q + 1'b1;
          if (i_q == nprev_q - 1'b1) begin
            drain_d = '0;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (!hold_active) begin
          if (drain_q == DRAIN_LAST) begin
            state_d = S_WRITE;
          end else begin
            drain_d = drain_q + 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (!hold_active) begin
          if (j_q == ncur_q - 1'b1) begin
            // Layer complete: the bank just written becomes the next layer's input.
            rd_base_d = wr_base_q;
            wr_base_d = rd_base_q;
            nprev_d   = ncur_q;
            ip_d      = ip_q + 1'b1;
            if (ip_q == '1) begin
              res_base_d  = wr_base_q;
              res_count_d = ncur_q;
              state_d     = S_DONE;
            end else begin
              state_d = S_FETCH;
            end
          end else begin
            j_d     = j_q + 1'b1;
            i_d     = '0;
            state_d = S_MAC;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    acc_en_d  = (state_d == S_MAC);
    wr_en_d   = (state_d == S_WRITE);
    forget_d  = (state_d == S_WRITE);
    busy_d    = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d    = (state_d == S_DONE);
    mac_rst_d = (state_d == S_IDLE) || (state_d == S_DONE);
  end

  // State, counters and registered strobes; reset returns everything to idle at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ip_q        <= '0;
      wptr_q      <= '0;
      rd_base_q   <= BASE_LOW;
      wr_base_q   <= BASE_HIGH;
      nprev_q     <= '0;
      ncur_q      <= '0;
      i_q         <= '0;
      j_q         <= '0;
      drain_q     <= '0;
      res_base_q  <= BASE_LOW;
      res_count_q <= '0;
      acc_en_q    <= 1'b0;
      wr_en_q     <= 1'b0;
      forget_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mac_rst_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      ip_q        <= ip_d;
      wptr_q      <= wptr_d;
      rd_base_q   <= rd_base_d;
      wr_base_q   <= wr_base_d;
      nprev_q     <= nprev_d;
      ncur_q      <= ncur_d;
      i_q         <= i_d;
      j_q         <= j_d;
      drain_q     <= drain_d;
      res_base_q  <= res_base_d;
      res_count_q <= res_count_d;
      acc_en_q    <= acc_en_d;
      wr_en_q     <= wr_en_d;
      forget_q    <= forget_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mac_rst_q   <= mac_rst_d;
    end
  end

  assign instr_addr          = (state_q == S_FETCH) ? ip_q : '0;
  assign weight_addr         = (state_q == S_MAC) ? wptr_q : '0;
  assign neuro_read_addr     = (state_q == S_MAC) ? (rd_base_q + i_q) : '0;
  assign neuro_write_addr    = (state_q == S_WRITE) ? (wr_base_q + j_q) : '0;
  assign mac_acc_en          = acc_en_q && !hold_active;
  assign neuro_wr_en         = wr_en_q && !hold_active;
  assign mac_forget          = forget_q && !hold_active;
  assign busy                = busy_q;
  assign done                = done_q;
  assign mac_rst             = mac_rst_q;
  assign result_base_address = res_base_q;
  assign result_word_count   = res_count_q;

endmodule

// File: tb/tb_inference_sequencer.sv
// tb/tb_inference_sequencer.sv - directed self-checking bench for inference_sequencer
module tb_inference_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] instr_addr, instr_data, weight_addr, neuro_read_addr, neuro_write_addr;
  logic       neuro_wr_en, mac_rst, mac_forget, mac_acc_en, busy, done;
  logic [7:0] result_base_address, result_word_count;
`ifdef SEQ_HOLD_EN
  logic       hold = 1'b0;
`endif

  logic [7:0] instr_mem [256];
  assign instr_data = instr_mem[instr_addr];

  int n_vec = 0;
  int n_miss = 0;

  int wr_log[$];
  int rd_log[$];
  int acc_idx;
  int wsweep_bad;
  int wmax;

  always #5 clk = ~clk;

  inference_sequencer dut (
    .clk                 (clk),
    .reset               (reset),
    .start               (start),
`ifdef SEQ_HOLD_EN
    .hold                (hold),
`endif
    .instr_addr          (instr_addr),
    .instr_data          (instr_data),
    .weight_addr         (weight_addr),
    .neuro_read_addr     (neuro_read_addr),
    .neuro_write_addr    (neuro_write_addr),
    .neuro_wr_en         (neuro_wr_en),
    .mac_rst             (mac_rst),
    .mac_forget          (mac_forget),
    .mac_acc_en          (mac_acc_en),
    .busy                (busy),
    .done                (done),
    .result_base_address (result_base_address),
    .result_word_count   (result_word_count)
  );

  // Observe the RAM/ROM-facing strobes mid-cycle.
  always @(negedge clk) begin
    if (neuro_wr_en) wr_log.push_back(int'(neuro_write_addr));
    if (mac_acc_en) begin
      rd_log.push_back(int'(neuro_read_addr));
      if (int'(weight_addr) != acc_idx) wsweep_bad++;
      if (int'(weight_addr) > wmax) wmax = int'(weight_addr);
      acc_idx++;
    end
  end

  function automatic int q_diff(input int a[$], input int b[$]);
    int d;
    d = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
    for (int k = 0; k < a.size() && k < b.size(); k++)
      if (a[k] != b[k]) d++;
    return d;
  endfunction

  task automatic load_prog(input int p[$]);
    for (int k = 0; k < 256; k++) instr_mem[k] = 8'h00;
    for (int k = 0; k < p.size(); k++) instr_mem[k] = 8'(p[k]);
  endtask

  task automatic clear_logs();
    wr_log.delete();
    rd_log.delete();
    acc_idx = 0;
    wsweep_bad = 0;
    wmax = 0;
  endtask

  // Pulse start, optionally pulse it again extra_at cycles later, and count edges until done.
  task automatic do_run(input int extra_at, output int cycles);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cycles = 0;
    while (cycles < 300) begin
      start = (cycles == extra_at);
      @(negedge clk);
      cycles++;
      if (done) break;
    end
    start = 1'b0;
    if (!done) cycles = -1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if ({instr_addr, weight_addr, neuro_read_addr, neuro_write_addr} !== 32'h0) begin
      n_miss++;
      $display("FAIL reset_addr got %h want 00000000", {instr_addr, weight_addr, neuro_read_addr, neuro_write_addr});
    end
    n_vec++;
    if ({neuro_wr_en, mac_acc_en, mac_forget, busy, done, mac_rst} !== 6'b000001) begin
      n_miss++;
      $display("FAIL reset_strobes got %b want 000001", {neuro_wr_en, mac_acc_en, mac_forget, busy, done, mac_rst});
    end
    n_vec++;
    if ({result_base_address, result_word_count} !== 16'h0000) begin
      n_miss++;
      $display("FAIL reset_result got %h want 0000", {result_base_address, result_word_count});
    end
    reset = 1'b0;
  endtask

  task automatic test_two_layer();
    int cyc;
    load_prog('{2, 3, 255});
    clear_logs();
    do_run(-1, cyc);
    n_vec++;
    if (cyc !== 18) begin n_miss++; $display("FAIL two_layer_cycles got %0d want 18", cyc); end
    n_vec++;
    if (result_base_address !== 8'd20 || result_word_count !== 8'd3) begin
      n_miss++;
      $display("FAIL two_layer_result got base=%0d count=%0d want base=20 count=3", result_base_address, result_word_count);
    end
    n_vec++;
    if (q_diff(wr_log, '{20, 21, 22}) !== 0) begin
      n_miss++;
      $display("FAIL two_layer_writes got %0d writes (%0d diffs) want 20,21,22", wr_log.size(), q_diff(wr_log, '{20, 21, 22}));
    end
    n_vec++;
    if (q_diff(rd_log, '{0, 1, 0, 1, 0, 1}) !== 0) begin
      n_miss++;
      $display("FAIL two_layer_reads got %0d reads (%0d diffs) want 0,1,0,1,0,1", rd_log.size(), q_diff(rd_log, '{0, 1, 0, 1, 0, 1}));
    end
    n_vec++;
    if (wsweep_bad !== 0 || acc_idx !== 6) begin
      n_miss++;
      $display("FAIL two_layer_weights got bad=%0d count=%0d want bad=0 count=6", wsweep_bad, acc_idx);
    end
    n_vec++;
    if ({busy, done} !== 2'b01) begin n_miss++; $display("FAIL two_layer_flags got %b want 01", {busy, done}); end
  endtask

  task automatic test_empty_program();
    int cyc;
    for (int v = 0; v < 2; v++) begin
      if (v == 0) load_prog('{255});
      else        load_prog('{0});
      clear_logs();
      do_run(-1, cyc);
      n_vec++;
      if (cyc !== 1) begin n_miss++; $display("FAIL empty%0d_cycles got %0d want 1", v, cyc); end
      n_vec++;
      if (result_base_address !== 8'd0 || result_word_count !== 8'd0) begin
        n_miss++;
        $display("FAIL empty%0d_result got base=%0d count=%0d want 0/0", v, result_base_address, result_word_count);
      end
      n_vec++;
      if (wr_log.size() !== 0) begin n_miss++; $display("FAIL empty%0d_writes got %0d want 0", v, wr_log.size()); end
    end
  endtask

  task automatic test_three_layer();
    int cyc;
    load_prog('{2, 2, 1, 255});
    clear_logs();
    do_run(-1, cyc);
    n_vec++;
    if (cyc !== 19) begin n_miss++; $display("FAIL three_layer_cycles got %0d want 19", cyc); end
    n_vec++;
    if (result_base_address !== 8'd0 || result_word_count !== 8'd1) begin
      n_miss++;
      $display("FAIL three_layer_result got base=%0d count=%0d want base=0 count=1", result_base_address, result_word_count);
    end
    n_vec++;
    if (q_diff(wr_log, '{20, 21, 0}) !== 0) begin
      n_miss++;
      $display("FAIL three_layer_writes got %0d writes (%0d diffs) want 20,21,0", wr_log.size(), q_diff(wr_log, '{20, 21, 0}));
    end
    n_vec++;
    if (q_diff(rd_log, '{0, 1, 0, 1, 20, 21}) !== 0) begin
      n_miss++;
      $display("FAIL three_layer_reads got %0d reads (%0d diffs) want 0,1,0,1,20,21", rd_log.size(), q_diff(rd_log, '{0, 1, 0, 1, 20, 21}));
    end
    n_vec++;
    if (wmax !== 5 || wsweep_bad !== 0) begin
      n_miss++;
      $display("FAIL three_layer_weights got max=%0d bad=%0d want max=5 bad=0", wmax, wsweep_bad);
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    load_prog('{2, 3, 255});
    clear_logs();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if ({mac_acc_en, busy} !== 2'b11) begin n_miss++; $display("FAIL midrun_in_mac got %b want 11", {mac_acc_en, busy}); end
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if ({instr_addr, weight_addr, neuro_read_addr, neuro_write_addr} !== 32'h0) begin
      n_miss++;
      $display("FAIL midrun_reset_addr got %h want 00000000", {instr_addr, weight_addr, neuro_read_addr, neuro_write_addr});
    end
    n_vec++;
    if ({neuro_wr_en, mac_acc_en, mac_forget, busy, done, mac_rst} !== 6'b000001) begin
      n_miss++;
      $display("FAIL midrun_reset_strobes got %b want 000001", {neuro_wr_en, mac_acc_en, mac_forget, busy, done, mac_rst});
    end
    @(negedge clk) reset = 1'b0;
    clear_logs();
    do_run(-1, cyc);
    n_vec++;
    if (cyc !== 18) begin n_miss++; $display("FAIL midrun_rerun_cycles got %0d want 18", cyc); end
    n_vec++;
    if (q_diff(wr_log, '{20, 21, 22}) !== 0 || wsweep_bad !== 0) begin
      n_miss++;
      $display("FAIL midrun_rerun_seq got writes=%0d bad_weights=%0d want writes=3 bad_weights=0", wr_log.size(), wsweep_bad);
    end
  endtask

  task automatic test_start_while_busy();
    int cyc;
    load_prog('{2, 3, 255});
    clear_logs();
    do_run(7, cyc);
    n_vec++;
    if (cyc !== 18) begin n_miss++; $display("FAIL busy_start_cycles got %0d want 18", cyc); end
    n_vec++;
    if (q_diff(wr_log, '{20, 21, 22}) !== 0 || q_diff(rd_log, '{0, 1, 0, 1, 0, 1}) !== 0) begin
      n_miss++;
      $display("FAIL busy_start_seq got writes=%0d reads=%0d want writes=3 reads=6 in order", wr_log.size(), rd_log.size());
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    clear_logs();
    do_run(-1, cyc);
    n_vec++;
    if (cyc !== 18) begin n_miss++; $display("FAIL rerun_cycles got %0d want 18", cyc); end
    n_vec++;
    if (q_diff(wr_log, '{20, 21, 22}) !== 0 || wsweep_bad !== 0 || acc_idx !== 6) begin
      n_miss++;
      $display("FAIL rerun_seq got writes=%0d bad_weights=%0d accs=%0d want 3/0/6", wr_log.size(), wsweep_bad, acc_idx);
    end
    n_vec++;
    if (result_base_address !== 8'd20 || result_word_count !== 8'd3) begin
      n_miss++;
      $display("FAIL rerun_result got base=%0d count=%0d want base=20 count=3", result_base_address, result_word_count);
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    clear_logs();
    load_prog('{255});
    #2 reset = 1'b1;
    test_reset();
    test_two_layer();
    test_empty_program();
    test_three_layer();
    test_reset_mid_run();
    test_start_while_busy();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
